// File: rtl/bit_pattern_tx_pkg.sv
// ============================================================================
// bit_pattern_tx_pkg : shared types, defaults and helpers for bit_pattern_tx
// Revision: 1.0
// ============================================================================
`default_nettype none

package bit_pattern_tx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A zero or oversize length selects the full register width.
  function automatic int unsigned eff_len_clamp(input int unsigned len,
                                                input int unsigned width);
    if ((len == 0) || (len > width)) begin
      return width;
    end
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_pattern_tx_if.sv
// ============================================================================
// bit_pattern_tx_if : request/pattern inputs and serial outputs of bit_pattern_tx
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bit_pattern_tx_if
  import bit_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int REP_W = DEF_REP_W
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, len, reps,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, reps,
    output out, out_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/bit_pattern_tx_shreg.sv
// ============================================================================
// bit_pattern_tx_shreg : WIDTH-bit loadable left-shift register, zero fill
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_pattern_tx_shreg #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] din,
  output logic                  msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= din;
    end else if (shift) begin
      r_data <= {r_data[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = r_data[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/bit_pattern_tx.sv
// ============================================================================
// bit_pattern_tx : MSB-first serial pattern transmitter with repeat and gap.
// Optional even-parity bit per frame when BIT_PATTERN_TX_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_pattern_tx
  import bit_pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int REP_W = DEF_REP_W
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  bit_pattern_tx_if.slave   bus
);

`ifdef BIT_PATTERN_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_cap;
  logic [LEN_W-1:0] r_eff;
  logic [LEN_W-1:0] r_cnt;
  logic [REP_W-1:0] r_rep;
  logic             r_parity;
  logic             r_par_phase;
  logic             r_out;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_eff;
  logic [LEN_W-1:0] w_sh;
  logic [WIDTH-1:0] w_aligned;
  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_din;
  logic             w_msb;

  assign w_eff     = LEN_W'(eff_len_clamp(32'(bus.len), WIDTH));
  assign w_sh      = LEN_W'(WIDTH) - w_eff;
  assign w_aligned = bus.pattern << w_sh;
  assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.abort;

  // The register always holds the bits after the one currently on out.
  assign w_load  = w_accept || ((r_state == ST_GAP) && !bus.abort);
  assign w_shift = (r_state == ST_SHIFT) && !bus.abort && (r_cnt > LEN_W'(1));
  assign w_din   = (r_state == ST_IDLE) ? (w_aligned << 1) : (r_cap << 1);

  bit_pattern_tx_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_din),
    .msb   (w_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cap       <= '0;
      r_eff       <= '0;
      r_cnt       <= '0;
      r_rep       <= '0;
      r_parity    <= 1'b0;
      r_par_phase <= 1'b0;
      r_out       <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (w_accept) begin
            r_cap       <= w_aligned;
            r_eff       <= w_eff;
            r_cnt       <= w_eff;
            r_rep       <= bus.reps;
            r_parity    <= ^w_aligned;
            r_par_phase <= 1'b0;
            r_out       <= w_aligned[WIDTH-1];
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bus.abort) begin
            r_out       <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_par_phase <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (r_cnt > LEN_W'(1)) begin
            r_out <= w_msb;
            r_cnt <= r_cnt - LEN_W'(1);
          end else if (PAR_EN && !r_par_phase) begin
            r_out       <= r_parity;
            r_par_phase <= 1'b1;
          end else begin
            r_out       <= 1'b0;
            r_valid     <= 1'b0;
            r_par_phase <= 1'b0;
            if (r_rep != '0) begin
              r_state <= ST_GAP;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_GAP: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            // Replay from the captured copy so live inputs cannot leak in.
            r_out   <= r_cap[WIDTH-1];
            r_valid <= 1'b1;
            r_cnt   <= r_eff;
            r_rep   <= r_rep - REP_W'(1);
            r_state <= ST_SHIFT;
          end
        end

        ST_DONE: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bit_pattern_tx.sv
// ============================================================================
// tb_bit_pattern_tx : directed + random frames against a frame-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bit_pattern_tx;

`ifdef BIT_PATTERN_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  bit_pattern_tx_if #(.WIDTH(8), .LEN_W(4), .REP_W(4)) bus ();

  bit_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [3:0] obs();
    return {bus.out, bus.out_valid, bus.busy, bus.done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {out,out_valid,busy,done} for every cycle after the start edge.
  task automatic build(input logic [7:0] pat, input int len, input int reps);
    int   l;
    logic p;
    l = ((len == 0) || (len > 8)) ? 8 : len;
    p = 1'b0;
    exp_q.delete();
    for (int i = 0; i < l; i++) p ^= pat[i];
    for (int r = 0; r <= reps; r++) begin
      for (int i = l - 1; i >= 0; i--) exp_q.push_back({pat[i], 3'b110});
      if (PAR) exp_q.push_back({p, 3'b110});
      if (r < reps) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endtask

  // Start a frame and check every cycle; optionally scribble on inputs while busy.
  task automatic run_frame(input string tag, input logic [7:0] pat, input int len,
                           input int reps, input bit junk);
    build(pat, len, reps);
    bus.pattern = pat;
    bus.len     = 4'(len);
    bus.reps    = 4'(reps);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_c%0d", tag, i + 1), 32'(obs()), 32'(exp_q[i]));
      if (junk && (i < exp_q.size() - 1)) begin
        bus.start   = 1'($urandom);
        bus.pattern = 8'($urandom);
        bus.len     = 4'($urandom);
        bus.reps    = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (i < exp_q.size() - 1) tick();
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.reps    = '0;
    rst_n       = 1'b0;
    #1;
    chk("reset_outputs", 32'(obs()), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(obs()), 32'h0);

    run_frame("p07_l3",   8'h07,  3, 0, 1'b0);
    run_frame("p0B_l4r2", 8'h0B,  4, 2, 1'b0);
    run_frame("pA5_l0",   8'hA5,  0, 0, 1'b0);
    run_frame("pA5_l12",  8'hA5, 12, 0, 1'b0);
    run_frame("p01_l1r1", 8'h01,  1, 1, 1'b0);
    run_frame("frozen",   8'hC3,  8, 1, 1'b1);

    // abort at cycle 4 of an all-ones frame
    bus.pattern = 8'hFF;
    bus.len     = 4'd8;
    bus.reps    = 4'd0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("abort_pre_c%0d", c), 32'(obs()), 32'b1110);
      if (c == 4) bus.abort = 1'b1;
      tick();
    end
    bus.abort = 1'b0;
    chk("abort_c5", 32'(obs()), 32'h0);
    tick();
    chk("abort_c6", 32'(obs()), 32'h0);
    run_frame("after_abort", 8'h5A, 8, 0, 1'b0);

    // abort together with start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_c1", 32'(obs()), 32'h0);
    tick();
    chk("abort_start_c2", 32'(obs()), 32'h0);

    // abort during a gap
    bus.pattern = 8'h03;
    bus.len     = 4'd2;
    bus.reps    = 4'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("gapabort_c2", 32'(obs()), 32'b1110);
    tick();
    chk("gapabort_gap", 32'(obs()), 32'b0010);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("gapabort_idle", 32'(obs()), 32'h0);
    tick();

    // asynchronous reset mid-frame
    bus.pattern = 8'hFF;
    bus.len     = 4'd8;
    bus.reps    = 4'd0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("rst_mid_before", 32'(obs()), 32'b1110);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", 32'(obs()), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_mid_idle", 32'(obs()), 32'h0);

    for (int n = 0; n < 10; n++) begin
      run_frame($sformatf("rnd%0d", n), 8'($urandom), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/bit_pattern_tx.md
# bit_pattern_tx

Serial bit-pattern transmitter: captures a parallel pattern word on a start request and shifts it out MSB-first on a single-bit line. It optionally repeats the frame, with a forced-zero gap cycle between repetitions. It is the stimulus/transmit end of the serial line consumed by the team's sequence detectors (run-of-ones detection). It also serves as an on-chip pattern source for exercising those detectors in silicon.

## Interface
Parameters:
- WIDTH, 8, pattern register width in bits (≥2)
- LEN_W, $clog2(WIDTH+1), width of the length field
- REP_W, 4, width of the repeat-count field

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  transmit request; sampled only in IDLE
- abort  in  1  synchronous abort of the current transmission
- pattern  in  WIDTH  frame bits; the low `len` bits are transmitted
- len  in  LEN_W  frame length; 0 or >WIDTH means WIDTH
- reps  in  REP_W  extra repetitions; the frame is sent reps+1 times
- out  out  1  serial data, registered
- out_valid  out  1  high while `out` carries a frame bit (or a parity bit)
- busy  out  1  high from the cycle after start acceptance until return to IDLE
- done  out  1  one-cycle pulse after the final bit of the final repetition

## Operation
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 and abort=0 → capture `pattern` left-aligned (shifted left by WIDTH−eff_len), capture eff_len and reps, load bit counter=eff_len, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - out = shift register MSB; out_valid=1.
  - Each cycle: shift left by one, fill with 0, decrement bit counter.
  - Counter reaches 1 and repetitions remain → GAP.
  - Counter reaches 1 and no repetitions remain → DONE.
- GAP: out=0, out_valid=0 for exactly one cycle. Reload the shift register from the captured pattern (not the live input), decrement the repeat counter, go to SHIFT.
- DONE: done=1, busy=1, out=0, out_valid=0 for one cycle, then IDLE.
- start in any state other than IDLE is ignored. No queuing.
- abort=1 in SHIFT, GAP or DONE → IDLE on the next edge. out, out_valid and busy are 0 from that edge; done is not pulsed.
- abort=1 together with start in IDLE → abort wins, and the transmission does not start.
- Captured values are frozen for the whole transmission; changes on pattern/len/reps while busy have no effect.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, out=0, out_valid=0, busy=0, done=0, all counters 0. Reset takes effect immediately, including mid-frame.
- Start at edge k → the first frame bit is on out, with out_valid=1 and busy=1, in cycle k+1.
- Frame of L bits occupies cycles k+1 … k+L.
- Each repetition adds a 1-cycle gap plus L bit cycles.
- Total busy cycles = (reps+1)·L + reps + 1 (the final +1 is the DONE cycle).
- done is high in cycle k+(reps+1)·L+reps+1. IDLE is reached on the following edge, and a new start is accepted in that IDLE cycle.
- Arithmetic:
  - Counters are unsigned.
  - The repeat counter never wraps (it is decremented only when nonzero).
  - The bit counter never goes below 1 in SHIFT.

## Configuration
- Macro BIT_PATTERN_TX_PARITY_EN:
  - Defined → after the last frame bit of every repetition, one extra SHIFT-phase cycle drives the even-parity bit (XOR of the eff_len transmitted bits) with out_valid=1. The gap or DONE state follows it. Each repetition grows by 1 cycle.
  - Undefined → no parity cycle; timing exactly as above.

## Structure
- Package bit_pattern_tx_pkg holds:
  - the state enum typedef (IDLE, SHIFT, GAP, DONE)
  - default WIDTH/REP_W localparams
  - the effective-length clamp function
- One sub-module: bit_pattern_tx_shreg, a WIDTH-bit loadable left-shift register with zero fill. Its ports are load, shift, load data and MSB out. The top holds the FSM, the counters and the parity accumulator.

## Test plan
- WIDTH=8, pattern=8'h07, len=3, reps=0, start pulse at cycle 0:
  - out=1,1,1 with out_valid=1 in cycles 1–3
  - done=1 in cycle 4, busy=0 in cycle 5
  - parity build: extra bit 1 in cycle 4, done in cycle 5
- pattern=8'h0B, len=4, reps=2:
  - out sequence 1011 0 1011 0 1011, with out_valid low on both gap cycles
  - done in cycle 15
- len=0, pattern=8'hA5: 8 bits 10100101 transmitted; len=12 gives the same result.
- Start with pattern=8'hFF, len=8, abort at cycle 4:
  - out/out_valid/busy=0 from cycle 5, with no done pulse
  - a second start in cycle 6 transmits normally
- Mid-frame behaviour:
  - Toggling start and pattern mid-frame → ignored, and the original frame completes.
  - rst_n low mid-frame → all outputs 0 immediately, without waiting for a clock edge.
